// File: rtl/hash_result_scanner.sv
// hash_result_scanner
//
// Reads back the per-nonce result words (H0 of each final digest) that the
// hash engine left in shared memory. Each word is compared against a
// difficulty target. The block keeps the smallest hash seen and its index,
// then writes one packed summary word directly after the result array.
//
// Ports:
//   clk            system clock, also forwarded to the memory as mem_clk
//   reset          synchronous, active-high reset
//   start          single-cycle scan request, honoured only while idle
//   result_addr    base address of the result array (latched with start)
//   target         difficulty threshold (latched with start)
//   done           one-cycle pulse after the summary word has been written
//   found          at least one hash was strictly below target
//   hit_count      number of hashes strictly below target
//   best_nonce     index of the smallest hash (lowest index on ties)
//   best_hash      smallest hash value seen
//   mem_clk        copy of clk for the single-port memory
//   mem_we         memory write enable
//   mem_addr       memory address (16-bit, wraps modulo 2^16)
//   mem_write_data summary word
//   mem_read_data  read data, valid the cycle after the address is sampled
module hash_result_scanner #(
  parameter int NUM_NONCES = 16,
  parameter int NONCE_W    = $clog2(NUM_NONCES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        result_addr,
  input  logic [31:0]        target,
  output logic               done,
  output logic               found,
  output logic [NONCE_W:0]   hit_count,
  output logic [NONCE_W-1:0] best_nonce,
  output logic [31:0]        best_hash,
  output logic               mem_clk,
  output logic               mem_we,
  output logic [15:0]        mem_addr,
  output logic [31:0]        mem_write_data,
  input  logic [31:0]        mem_read_data
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] DRAIN  = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  localparam logic [NONCE_W-1:0] LAST_IDX   = NONCE_W'(NUM_NONCES - 1);
  localparam logic [NONCE_W-1:0] ISSUE_LAST = NONCE_W'(NUM_NONCES - 2);
  localparam logic [15:0]        ARRAY_LEN  = 16'(NUM_NONCES);

  logic [2:0]         state;
  logic [15:0]        base_q;
  logic [31:0]        target_q;
  logic [NONCE_W-1:0] issue_cnt;
  logic [NONCE_W-1:0] cap_cnt;
  logic               rd_v1;
  logic               rd_v2;
  logic [31:0]        summary_word;

  assign mem_clk = clk;

  // The summary packs the flag, an 8-bit hit count and a 16-bit nonce index.
  // It is built from the registered results, so by the time WRITE runs the
  // final capture has already been folded in.
  always_comb begin
    summary_word = {found, 7'b0, 8'(hit_count), 16'(best_nonce)};
  end

  // Main sequencer. Addresses are issued back to back; rd_v1/rd_v2 form a
  // two-stage valid pipeline that mirrors the memory's one-cycle read latency,
  // so a word is captured two edges after its address was registered. The
  // capture counter runs off that pipeline rather than the issue counter,
  // which lets the captures overlap ISSUE and spill into DRAIN naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      base_q         <= '0;
      target_q       <= '0;
      issue_cnt      <= '0;
      cap_cnt        <= '0;
      rd_v1          <= 1'b0;
      rd_v2          <= 1'b0;
      done           <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      found          <= 1'b0;
      hit_count      <= '0;
      best_nonce     <= '0;
      best_hash      <= 32'hFFFF_FFFF;
    end else begin
      rd_v1 <= 1'b0;
      rd_v2 <= rd_v1;
      done  <= 1'b0;

      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (start) begin
            base_q     <= result_addr;
            target_q   <= target;
            mem_addr   <= result_addr;
            issue_cnt  <= '0;
            cap_cnt    <= '0;
            hit_count  <= '0;
            found      <= 1'b0;
            best_hash  <= 32'hFFFF_FFFF;
            best_nonce <= '0;
            rd_v1      <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_addr  <= mem_addr + 16'd1;
          issue_cnt <= issue_cnt + NONCE_W'(1);
          rd_v1     <= 1'b1;
          if (issue_cnt == ISSUE_LAST) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rd_v2 && (cap_cnt == LAST_IDX)) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          mem_we         <= 1'b1;
          mem_addr       <= base_q + ARRAY_LEN;
          mem_write_data <= summary_word;
          state          <= FINISH;
        end
        FINISH: begin
          mem_we <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Strict comparisons: a hash equal to the target is not a hit, and a
      // hash equal to the current best does not displace the earlier index.
      if (rd_v2 && (state != IDLE)) begin
        cap_cnt <= cap_cnt + NONCE_W'(1);
        if (mem_read_data < target_q) begin
          hit_count <= hit_count + (NONCE_W+1)'(1);
          found     <= 1'b1;
        end
        if (mem_read_data < best_hash) begin
          best_hash  <= mem_read_data;
          best_nonce <= cap_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_hash_result_scanner.sv
// tb_hash_result_scanner
//
// Drives hash_result_scanner against a simple single-port memory model and
// checks every cycle of each scan against a behavioural model that derives
// the expected hits, minimum and summary word straight from the word array.
module tb_hash_result_scanner;

  localparam int N  = 16;
  localparam int NW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   result_addr = '0;
  logic [31:0]   target = '0;
  logic          done;
  logic          found;
  logic [NW:0]   hit_count;
  logic [NW-1:0] best_nonce;
  logic [31:0]   best_hash;
  logic          mem_clk;
  logic          mem_we;
  logic [15:0]   mem_addr;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;

  hash_result_scanner #(.NUM_NONCES(N)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .result_addr(result_addr),
    .target(target),
    .done(done),
    .found(found),
    .hit_count(hit_count),
    .best_nonce(best_nonce),
    .best_hash(best_hash),
    .mem_clk(mem_clk),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory model: address sampled on the rising edge, data shown the
  // following cycle. Writes are logged rather than stored.
  logic [31:0] mem [0:65535];
  logic [15:0] rd_addr_q = '0;
  logic [15:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  int          wr_count = 0;
  int          cyc = 0;

  assign mem_read_data = mem[rd_addr_q];

  always @(posedge mem_clk) begin
    rd_addr_q <= mem_addr;
    cyc       <= cyc + 1;
    if (mem_we) begin
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_write_data;
      wr_count     <= wr_count + 1;
    end
  end

  int done_cnt = 0;
  int done_cyc = 0;
  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // Model state
  logic [31:0] w [0:N-1];
  logic        exp_found;
  int          exp_hits;
  int          exp_nonce;
  logic [31:0] exp_hash;
  logic [31:0] exp_summary;
  logic [15:0] base_m;
  int          t0 = 0;
  bit          active = 0;
  bit          idle_valid = 0;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=%h expected=%h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Expected results from the word array: count words below target, take the
  // minimum value, and report the first index holding that minimum.
  task automatic computeModel(input logic [31:0] tgt);
    exp_hits = 0;
    exp_hash = 32'hFFFF_FFFF;
    foreach (w[i]) begin
      if (w[i] < tgt) exp_hits++;
      if (w[i] < exp_hash) exp_hash = w[i];
    end
    exp_nonce = -1;
    foreach (w[i]) begin
      if (exp_nonce < 0 && w[i] == exp_hash) exp_nonce = i;
    end
    if (exp_nonce < 0) exp_nonce = 0;
    exp_found   = (exp_hits > 0);
    exp_summary = (exp_found ? 32'h8000_0000 : 32'h0) | (32'(exp_hits & 8'hFF) << 16) | 32'(exp_nonce);
  endtask

  task automatic setIdleReset();
    exp_found = 1'b0;
    exp_hits  = 0;
    exp_nonce = 0;
    exp_hash  = 32'hFFFF_FFFF;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_done"},   32'(done), 32'h0);
    checkOutput({tag, "_we"},     32'(mem_we), 32'h0);
    checkOutput({tag, "_addr"},   32'(mem_addr), 32'h0);
    checkOutput({tag, "_wdata"},  mem_write_data, 32'h0);
    checkOutput({tag, "_found"},  32'(found), 32'h0);
    checkOutput({tag, "_hits"},   32'(hit_count), 32'h0);
    checkOutput({tag, "_nonce"},  32'(best_nonce), 32'h0);
    checkOutput({tag, "_hash"},   best_hash, 32'hFFFF_FFFF);
  endtask

  // Per-cycle compare against the timing rules: address i registered at
  // edge T+i, summary write at T+N+2, done at T+N+3.
  always @(posedge clk) begin
    int k;
    logic [15:0] ea;
    #2;
    if (!reset) begin
      if (active) begin
        k = cyc - t0;
        if (k <= N + 1) begin
          ea = base_m + 16'((k < N) ? k : N - 1);
          checkOutput("scan_we", 32'(mem_we), 32'h0);
          checkOutput("scan_done", 32'(done), 32'h0);
          checkOutput("scan_addr", 32'(mem_addr), 32'(ea));
        end else if (k == N + 2) begin
          ea = base_m + 16'(N);
          checkOutput("wr_we", 32'(mem_we), 32'h1);
          checkOutput("wr_addr", 32'(mem_addr), 32'(ea));
          checkOutput("wr_data", mem_write_data, exp_summary);
          checkOutput("wr_done", 32'(done), 32'h0);
        end else begin
          checkOutput("fin_done", 32'(done), 32'h1);
          checkOutput("fin_we", 32'(mem_we), 32'h0);
          checkOutput("fin_found", 32'(found), 32'(exp_found));
          checkOutput("fin_hits", 32'(hit_count), 32'(exp_hits));
          checkOutput("fin_nonce", 32'(best_nonce), 32'(exp_nonce));
          checkOutput("fin_hash", best_hash, exp_hash);
          active     = 0;
          idle_valid = 1;
        end
      end else if (idle_valid) begin
        checkOutput("idle_done", 32'(done), 32'h0);
        checkOutput("idle_we", 32'(mem_we), 32'h0);
        checkOutput("hold_found", 32'(found), 32'(exp_found));
        checkOutput("hold_hits", 32'(hit_count), 32'(exp_hits));
        checkOutput("hold_nonce", 32'(best_nonce), 32'(exp_nonce));
        checkOutput("hold_hash", best_hash, exp_hash);
      end
    end
  end

  // Load the word array at base (wrapping), start a scan and follow it to
  // completion. busy_k re-asserts start so it is sampled at edge T+busy_k;
  // reset_k asserts reset so it is sampled at edge T+reset_k.
  task automatic applyStimulus(input logic [15:0] base, input logic [31:0] tgt,
                               input int busy_k, input int reset_k);
    int  wc0;
    int  dc0;
    bit  did_reset;
    bit  timed_out;
    logic [15:0] a;
    did_reset = 0;
    timed_out = 1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      a = base + 16'(i);
      mem[a] = w[i];
    end
    computeModel(tgt);
    wc0         = wr_count;
    dc0         = done_cnt;
    base_m      = base;
    result_addr = base;
    target      = tgt;
    start       = 1'b1;
    t0          = cyc + 1;
    idle_valid  = 0;
    active      = 1;
    @(negedge clk);
    result_addr = 16'($urandom);
    target      = $urandom;
    for (int n = 0; n < 100; n++) begin
      start = 1'b0;
      if (!active) begin
        timed_out = 0;
        break;
      end
      if (busy_k >= 0 && cyc + 1 == t0 + busy_k) begin
        start  = 1'b1;
        target = ~tgt;
      end
      if (reset_k >= 0 && cyc + 1 == t0 + reset_k) begin
        reset      = 1'b1;
        active     = 0;
        idle_valid = 0;
        did_reset  = 1;
        timed_out  = 0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (timed_out) begin
      checkOutput("scan_timeout", 32'(active), 32'h0);
      active = 0;
    end
    if (did_reset) begin
      @(negedge clk);
      checkReset("midrst");
      reset = 1'b0;
      setIdleReset();
      idle_valid = 1;
      repeat (3) @(negedge clk);
      checkOutput("midrst_no_write", 32'(wr_count - wc0), 32'h0);
      checkOutput("midrst_no_done", 32'(done_cnt - dc0), 32'h0);
    end else begin
      repeat (3) @(negedge clk);
      checkOutput("one_done", 32'(done_cnt - dc0), 32'h1);
      checkOutput("one_write", 32'(wr_count - wc0), 32'h1);
      a = base + 16'(N);
      checkOutput("log_addr", 32'(last_wr_addr), 32'(a));
      checkOutput("log_data", last_wr_data, exp_summary);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkReset("init");
    reset = 1'b0;
    setIdleReset();
    idle_valid = 1;

    // Ascending results
    for (int i = 0; i < N; i++) w[i] = 32'(i) * 32'h1000_0000 + 32'h5;
    applyStimulus(16'h1000, 32'h3000_0000, -1, -1);
    checkOutput("asc_hits", 32'(hit_count), 32'd3);
    checkOutput("asc_found", 32'(found), 32'h1);
    checkOutput("asc_nonce", 32'(best_nonce), 32'h0);
    checkOutput("asc_hash", best_hash, 32'h0000_0005);
    checkOutput("asc_summary", last_wr_data, 32'h8003_0000);
    checkOutput("asc_sum_addr", 32'(last_wr_addr), 32'h1010);
    checkOutput("asc_latency", 32'(done_cyc - t0), 32'd19);

    // Minimum mid-array with a tie
    for (int i = 0; i < N; i++) w[i] = 32'hF000_0000;
    w[7]  = 32'h0000_1234;
    w[11] = 32'h0000_1234;
    applyStimulus(16'h2000, 32'h0000_1000, -1, -1);
    checkOutput("tie_found", 32'(found), 32'h0);
    checkOutput("tie_hits", 32'(hit_count), 32'h0);
    checkOutput("tie_nonce", 32'(best_nonce), 32'd7);
    checkOutput("tie_summary", last_wr_data, 32'h0000_0007);

    // Target zero: nothing can be a hit
    for (int i = 0; i < N; i++) w[i] = $urandom;
    w[2] = 32'h0;
    applyStimulus(16'h3000, 32'h0, -1, -1);
    checkOutput("t0_hits", 32'(hit_count), 32'h0);
    checkOutput("t0_found", 32'(found), 32'h0);

    // Target all ones: everything but an all-ones word hits
    for (int i = 0; i < N; i++) w[i] = 32'h0;
    w[3] = 32'hFFFF_FFFF;
    applyStimulus(16'h4000, 32'hFFFF_FFFF, -1, -1);
    checkOutput("tmax_hits", 32'(hit_count), 32'd15);
    checkOutput("tmax_summary", last_wr_data, 32'h800F_0000);

    // All words all-ones
    for (int i = 0; i < N; i++) w[i] = 32'hFFFF_FFFF;
    applyStimulus(16'h5000, $urandom, -1, -1);
    checkOutput("ones_hash", best_hash, 32'hFFFF_FFFF);
    checkOutput("ones_nonce", 32'(best_nonce), 32'h0);

    // Address wrap past 16'hFFFF
    for (int i = 0; i < N; i++) w[i] = $urandom;
    applyStimulus(16'hFFF8, $urandom, -1, -1);
    checkOutput("wrap_sum_addr", 32'(last_wr_addr), 32'h0008);

    // Start while busy is ignored
    for (int i = 0; i < N; i++) w[i] = $urandom;
    applyStimulus(16'h6000, 32'h8000_0000, 5, -1);

    // Mid-scan reset, then a fresh scan
    for (int i = 0; i < N; i++) w[i] = $urandom;
    applyStimulus(16'h7000, 32'h4000_0000, -1, 9);
    for (int i = 0; i < N; i++) w[i] = $urandom;
    applyStimulus(16'h7100, 32'h4000_0000, -1, -1);

    // Randomized scans with duplicates and mixed target styles
    for (int r = 0; r < 10; r++) begin
      logic [31:0] tg;
      for (int i = 0; i < N; i++) w[i] = ($urandom_range(0, 3) == 0) ? 32'h00AB_CDEF : $urandom;
      case ($urandom_range(0, 3))
        0: tg = $urandom;
        1: tg = w[$urandom_range(0, N - 1)];
        2: tg = 32'h0;
        default: tg = 32'hFFFF_FFFF;
      endcase
      applyStimulus(16'($urandom), tg, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hash_result_scanner.md
# hash_result_scanner

Post-processing block for the nonce-search engine. Once the hash engine has written its per-nonce results (word H0 of the final digest, one word per nonce) to shared memory at `result_addr`, this block reads them back over the same single-port memory interface. It compares each word against a difficulty target, picks the best (numerically smallest) hash, and writes one packed summary word after the result array. It is the reader of the engine's result region and shares the memory bus with the engine through the top-level arbiter.

## Interface
Parameters:
- `NUM_NONCES`, 16: number of result words to scan (2..256).
- `NONCE_W`, `$clog2(NUM_NONCES)`: width of the nonce index.

Ports:
- `clk`  in  1  system clock; also forwarded as `mem_clk`.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `result_addr`  in  16  base address of the result array; sampled with `start`.
- `target`  in  32  difficulty threshold; sampled with `start`.
- `done`  out  1  one-cycle pulse when the summary has been written.
- `found`  out  1  at least one hash < target; valid from `done` until the next `start`.
- `hit_count`  out  `NONCE_W+1`  number of hashes < target.
- `best_nonce`  out  `NONCE_W`  index of the minimum hash.
- `best_hash`  out  32  minimum hash value.
- `mem_clk`  out  1  equals `clk`.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  16  memory address.
- `mem_write_data`  out  32  write data.
- `mem_read_data`  in  32  read data. The memory samples `mem_addr` on a rising edge and presents data during the following cycle.

## Operation
- States: IDLE, ISSUE, DRAIN, WRITE, FINISH.
- **IDLE:** `mem_we`=0. On `start`:
  - latch `result_addr` and `target`;
  - set `mem_addr`<=`result_addr`;
  - clear the issue and capture counters, `hit_count`, and `found`;
  - set `best_hash`<=32'hFFFFFFFF and `best_nonce`<=0;
  - go to ISSUE.
- **ISSUE:** increment `mem_addr` each cycle until address `result_addr+NUM_NONCES-1` has been driven, then go to DRAIN.
- **Capture pipeline:** word i is captured two edges after address i was registered. A capture counter tracks index i independently of the issue counter.
- **Per captured word h, index i:**
  - if h < `target` (unsigned, strict), increment `hit_count` and set `found`;
  - if h < `best_hash` (strict), update `best_hash`<=h and `best_nonce`<=i. On ties the lower index is kept.
- **DRAIN:** wait until the last word is captured. Leave `mem_addr` at its last value.
- **WRITE:** for one cycle:
  - `mem_we`=1;
  - `mem_addr`=`result_addr+NUM_NONCES` (16-bit wrap);
  - `mem_write_data`={`found`, 7'b0, 8-bit zero-extended `hit_count`, 16-bit zero-extended `best_nonce`}, using the final values including the last capture.
- **FINISH:** `mem_we`=0, `done`=1 for one cycle, then return to IDLE.
- **Result outputs** hold their values until the next accepted `start`.
- **Address arithmetic** is 16-bit modulo. A result array crossing 16'hFFFF wraps to 0.
- **`start` while busy** is ignored and does not restart the scan.
- **`target`=0:** no hit is possible; `found`=0 and `hit_count`=0.
- **`target`=32'hFFFFFFFF:** every word except 32'hFFFFFFFF is a hit.
- **All words 32'hFFFFFFFF:** `best_hash`=32'hFFFFFFFF and `best_nonce`=0.

## Timing
- **Reset** takes priority over all other behaviour, including mid-scan. Outputs next cycle:
  - state IDLE;
  - `done`=0, `mem_we`=0, `mem_addr`=0, `mem_write_data`=0;
  - `found`=0, `hit_count`=0, `best_nonce`=0, `best_hash`=32'hFFFFFFFF.
- **Mid-scan reset:** no summary write occurs and there is no `done` pulse.
- **Cycle numbering:** `start` accepted at edge T.
  - address i is registered at edge T+i;
  - word i is captured at edge T+i+2;
  - the last capture is at T+NUM_NONCES+1.
- **Summary write:** `mem_we`=1 is registered at edge T+NUM_NONCES+2 and held exactly one cycle.
- **`done`:** registered high at edge T+NUM_NONCES+3, concurrently with `mem_we` returning to 0.
- **Latency:** `start` to `done` is NUM_NONCES+3 cycles (19 for the default). The earliest next `start` is accepted the cycle after `done`.
- **No write during the scan:** `mem_we` is never high during ISSUE or DRAIN.

## Test plan
- **Ascending results:** words[i]=i*0x10000000+5, `target`=0x30000000 -> `hit_count`=3, `found`=1, `best_nonce`=0, `best_hash`=0x00000005; summary at `result_addr`+16 = 0x80030000; `done` exactly 19 cycles after `start`.
- **Minimum mid-array with tie:** words all 0xF0000000 except [7]=[11]=0x00001234, `target`=0x00001000 -> `found`=0, `hit_count`=0, `best_nonce`=7, summary 0x00000007.
- **Boundary targets:** `target`=0 -> `hit_count`=0. `target`=0xFFFFFFFF with words[3]=0xFFFFFFFF, others 0 -> `hit_count`=15.
- **Address wrap:** `result_addr`=16'hFFF8 -> reads 0xFFF8..0xFFFF, 0x0000..0x0007; summary written at 0x0008.
- **Busy `start`:** re-assert `start` with a new `target` at T+5 -> ignored; results match the original `target`; exactly one `done`.
- **Mid-scan reset:** assert `reset` at T+9 -> next cycle every output is at its reset value; no `mem_we` pulse; a fresh `start` afterward produces a correct scan.
